// File: rtl/sram_dma_pkg.sv
// sram_dma_pkg: shared state encoding and default geometry for the SRAM copy engine.
package sram_dma_pkg;
    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 256;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);
    localparam int DEF_LEN_WIDTH = DEF_ADDR_WIDTH + 1;
endpackage

// File: rtl/sram_dma_if.sv
// sram_dma_if: command/status channel between the core (master) and the copy engine (slave).
// SRAM_DMA_FILL_EN adds the fill command fields.
interface sram_dma_if import sram_dma_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef SRAM_DMA_FILL_EN
    , parameter int WIDTH = DEF_WIDTH
`endif
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_src;
    logic [ADDR_WIDTH-1:0] cmd_dst;
    logic [ADDR_WIDTH:0]   cmd_len;
    logic                  busy;
    logic                  done;
    logic                  err;
`ifdef SRAM_DMA_FILL_EN
    logic                  cmd_fill;
    logic [WIDTH-1:0]      cmd_fill_data;
    modport master (output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_fill_data,
                    input cmd_ready, busy, done, err);
    modport slave (input cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_fill_data,
                   output cmd_ready, busy, done, err);
`else
    modport master (output cmd_valid, cmd_src, cmd_dst, cmd_len,
                    input cmd_ready, busy, done, err);
    modport slave (input cmd_valid, cmd_src, cmd_dst, cmd_len,
                   output cmd_ready, busy, done, err);
`endif
endinterface

// File: rtl/sram_dma_chk.sv
// sram_dma_chk: flags commands whose ranges leave the SRAM or whose copy would overwrite
// unread source words.
module sram_dma_chk import sram_dma_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  fill,
    output logic                  reject
);
    localparam int LW = ADDR_WIDTH + 1;
    logic [ADDR_WIDTH:0] lim, src_end, dst_end;
    assign lim = LW'(DEPTH);
    assign src_end = {1'b0, src} + len;
    assign dst_end = {1'b0, dst} + len;
    // len above DEPTH would let the sums wrap, so it is rejected outright
    assign reject = (len > lim) || (!fill && src_end > lim) || (dst_end > lim) ||
                    (!fill && len != '0 && dst > src && {1'b0, dst} < src_end);
endmodule

// File: rtl/sram_dma.sv
// sram_dma: pipelined SRAM block copy engine, reads on port B and writes on port A.
// SRAM_DMA_FILL_EN adds pattern-fill commands.
module sram_dma import sram_dma_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_dma_if.slave             cmd,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [WIDTH-1:0]      mem_wdata_a,
    output logic                  mem_write_en_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    input  logic [WIDTH-1:0]      mem_rdata_b
);
    localparam int LW = ADDR_WIDTH + 1;
    state_t state;
    logic [ADDR_WIDTH:0] rem;
    logic busy, done, err, reject, start, last, fill, fill_req;

    assign cmd.cmd_ready = state == IDLE;
    assign cmd.busy = busy;
    assign cmd.done = done;
    assign cmd.err = err;
    assign start = cmd.cmd_valid && state == IDLE;
    assign last = rem == LW'(1);

`ifdef SRAM_DMA_FILL_EN
    logic [WIDTH-1:0] fill_data;
    assign fill_req = cmd.cmd_fill;
    assign mem_wdata_a = !mem_write_en_a ? '0 : fill ? fill_data : mem_rdata_b;
`else
    assign fill_req = 1'b0;
    assign fill = 1'b0;
    assign mem_wdata_a = mem_write_en_a ? mem_rdata_b : '0;
`endif

    sram_dma_chk #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_chk (
        .src(cmd.cmd_src),
        .dst(cmd.cmd_dst),
        .len(cmd.cmd_len),
        .fill(fill_req),
        .reject(reject)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            mem_write_en_a <= 1'b0;
            mem_addr_a <= '0;
            mem_addr_b <= '0;
`ifdef SRAM_DMA_FILL_EN
            fill <= 1'b0;
            fill_data <= '0;
`endif
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (start) begin
`ifdef SRAM_DMA_FILL_EN
                    fill <= fill_req;
                    fill_data <= cmd.cmd_fill_data;
`endif
                    if (reject) err <= 1'b1;
                    else if (cmd.cmd_len == '0) done <= 1'b1;
                    else begin
                        state <= RUN;
                        busy <= 1'b1;
                        rem <= cmd.cmd_len;
                        mem_addr_a <= cmd.cmd_dst;
                        mem_addr_b <= fill_req ? '0 : cmd.cmd_src;
                        mem_write_en_a <= fill_req;
                    end
                end
                RUN: begin
                    rem <= rem - 1'b1;
                    if (fill) begin
                        mem_addr_a <= mem_addr_a + 1'b1;
                        if (last) begin
                            state <= IDLE;
                            busy <= 1'b0;
                            done <= 1'b1;
                            mem_write_en_a <= 1'b0;
                        end
                    end else begin
                        // write address trails the read address by one cycle
                        mem_write_en_a <= 1'b1;
                        if (mem_write_en_a) mem_addr_a <= mem_addr_a + 1'b1;
                        mem_addr_b <= last ? '0 : mem_addr_b + 1'b1;
                        if (last) state <= LAST;
                    end
                end
                LAST: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                    mem_write_en_a <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
